// File: rtl/mips_cpu_instr_memory.sv
// Instruction memory for the MIPS CPU. A program image is streamed in
// word by word after load_start, then served to the fetch port combinationally.
module mips_cpu_instr_memory #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clk_enable,
  input  logic [31:0]                     instr_address,
  output logic [31:0]                     instr_readdata,
  input  logic                            load_start,
  input  logic                            load_valid,
  input  logic [31:0]                     load_data,
  input  logic                            load_last,
  output logic                            load_ready,
  output logic                            mem_ready,
  output logic [$clog2(DEPTH_WORDS):0]    word_count
);

  // state | meaning
  // EMPTY | no program image; fetches return NOP
  // LOAD  | accepting image words in ascending order from word 0
  // READY | image complete; fetches within word_count return stored words

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

  state_t      state;
  logic [31:0] mem [DEPTH_WORDS];
  logic        accept;
  logic        full_word;
  logic [31:0] offset;
  logic [31:0] read_idx;
  logic        hit;

  assign accept    = clk_enable && load_valid && load_ready;
  assign full_word = (word_count == CW'(DEPTH_WORDS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      word_count <= '0;
      load_ready <= 1'b0;
      mem_ready  <= 1'b0;
    end else if (clk_enable) begin
      case (state)
        EMPTY: begin
          if (load_start) begin
            state      <= LOAD;
            word_count <= '0;
            load_ready <= 1'b1;
          end
        end
        LOAD: begin
          // load_start is deliberately ignored here; only a completed image can restart
          if (accept) begin
            word_count <= word_count + CW'(1);
            if (load_last || full_word) begin
              state      <= READY;
              load_ready <= 1'b0;
              mem_ready  <= 1'b1;
            end
          end
        end
        READY: begin
          if (load_start) begin
            state      <= LOAD;
            word_count <= '0;
            load_ready <= 1'b1;
            mem_ready  <= 1'b0;
          end
        end
        default: begin
          state      <= EMPTY;
          word_count <= '0;
          load_ready <= 1'b0;
          mem_ready  <= 1'b0;
        end
      endcase
    end
  end

  // Storage is not reset; the word_count bound keeps stale words hidden.
  always_ff @(posedge clk) begin
    if (accept) mem[word_count[AW-1:0]] <= load_data;
  end

  // Addresses below BASE_ADDR wrap to huge indices and fail the bound check.
  assign offset   = instr_address - BASE_ADDR;
  assign read_idx = offset >> 2;
  assign hit      = (state == READY) && (instr_address[1:0] == 2'b00) &&
                    (read_idx < 32'(word_count));

  always_comb begin
    instr_readdata = 32'h0;
    if (hit) instr_readdata = mem[read_idx[AW-1:0]];
  end

endmodule

// File: doc/mips_cpu_instr_memory.md
MIPS_CPU_INSTR_MEMORY -- requirements
Module: mips_cpu_instr_memory

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit instruction words stored; power of two, 4..4096.
REQ-002 Parameter BASE_ADDR, default 32'hBFC00000: byte address of word 0 (reset vector).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: clk_enable  input  1  global stall; when low, no state, counter or memory update occurs.
REQ-006 Port: instr_address  input  32  CPU fetch byte address.
REQ-007 Port: instr_readdata  output  32  fetched instruction, combinational from instr_address.
REQ-008 Port: load_start  input  1  request to (re)load program image.
REQ-009 Port: load_valid  input  1  load_data holds a valid word.
REQ-010 Port: load_data  input  32  program word, written in ascending address order from word 0.
REQ-011 Port: load_last  input  1  qualifies the final word of the image.
REQ-012 Port: load_ready  output  1  block accepts a load word this cycle.
REQ-013 Port: mem_ready  output  1  program loaded; CPU may fetch (high only in READY).
REQ-014 Port: word_count  output  log2(DEPTH_WORDS)+1  number of words loaded.

Function
REQ-015 FSM states: EMPTY, LOAD, READY; all transitions need clk_enable=1 at the rising edge.
REQ-016 EMPTY -> LOAD on load_start=1; word_count cleared to 0 on the same edge.
REQ-017 LOAD: load_ready=1 while word_count < DEPTH_WORDS; otherwise load_ready=0.
REQ-018 Handshake: word accepted when load_valid && load_ready && clk_enable at the edge; written to mem[word_count]; word_count increments by 1.
REQ-019 LOAD -> READY on acceptance of a word with load_last=1, or on acceptance of word DEPTH_WORDS-1 (full) regardless of load_last.
REQ-020 LOAD with load_valid=0 holds state; no timeout.
REQ-021 load_start in LOAD is ignored; load_start in READY -> LOAD with word_count cleared to 0 (restart; previous contents no longer readable).
REQ-022 Read index = (instr_address - BASE_ADDR) >> 2, 32-bit modulo subtraction.
REQ-023 instr_readdata = mem[index] only when state=READY, instr_address[1:0]=0, and index < word_count; otherwise 32'h00000000 (NOP).
REQ-024 Addresses below BASE_ADDR (incl. 0x00000000) wrap to huge indices and return 0; there is no wrap into the array.
REQ-025 Read path purely combinational: new instr_address reflected in instr_readdata same cycle, zero-cycle latency.
REQ-026 mem_ready = (state == READY); load_ready = 0 in EMPTY and READY.
REQ-027 The edge that accepts the final word also makes it readable: the word is visible in READY the next cycle.
REQ-028 Memory array is not cleared by reset; REQ-023 guarantees unwritten words read as 0.

Reset
REQ-029 reset=0 asynchronously forces state=EMPTY, word_count=0, load_ready=0, mem_ready=0, instr_readdata=0, independent of clk and clk_enable.
REQ-030 Reset asserted mid-LOAD aborts the load; partially written words become unreadable (word_count=0).
REQ-031 Deassertion is sampled at the next rising edge; first possible transition is EMPTY->LOAD on that edge.

Verification
REQ-032 Load 4 words 0x24A50009, 0x00A51021, 0x00000008, 0x24000000 (last on 4th) -> mem_ready=1, word_count=4; address 0xBFC00004 reads 0x00A51021; 0xBFC00010 reads 0.
REQ-033 Fetch from 0x00000000, 0xBFC00002, 0xBFBFFFFC in READY -> instr_readdata=0 each.
REQ-034 Load with clk_enable=0 for 3 cycles while load_valid=1 -> word_count unchanged for those cycles; resumes on re-enable without loss or duplication.
REQ-035 DEPTH_WORDS=4, stream 6 words with load_last never set -> READY after 4th word, load_ready=0, word_count=4, words 5-6 not accepted.
REQ-036 reset=0 after 2 of 4 words accepted, asserted between clock edges -> immediately mem_ready=0, word_count=0, instr_readdata=0; fresh 4-word reload then behaves as REQ-032.
REQ-037 load_start in READY, then 1 word 0xDEADBEEF with load_last -> word_count=1; 0xBFC00000 reads 0xDEADBEEF, 0xBFC00004 reads 0.
